ir_dispatch_queue: RTL and testbench
====================================

# ir_dispatch_queue

Parametrised instruction-dispatch queue for the EBOX IR path. It accepts instruction words (opcode + AC), forms the dispatch-RAM (DRAM) address with the I/O-7XX and JRST mappings, and performs a one-cycle synchronous DRAM lookup. Each decoded entry {IR, IRAC, A, B, J, parity status} is buffered in a DEPTH-entry FIFO, so CON/CTL can prefetch several instructions ahead of the microcode dispatch. The DRAM is loaded through a diagnostic write port.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥2.
- DRAM_ADDR_BITS, 9: DRAM address width (512 words).
- DRAM_WIDTH, 15: DRAM word, packed as A[0:2], B[0:2], PAR, J[1:4], J[7:10].
- clk  in  1  EBOX clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instruction word offered.
- in_ready  out  1  word accepted when in_valid & in_ready.
- in_word  in  [0:12]  opcode [0:8], AC [9:12].
- flush  in  1  discard queue and in-flight lookup.
- en_io_jrst  in  1  enables 7XX I/O remap and JRST AC dispatch.
- en_ac  in  1  IRAC = AC when 1, else 0.
- dram_we  in  1  diagnostic DRAM write strobe.
- dram_waddr  in  [0:DRAM_ADDR_BITS-1]  write address.
- dram_wdata  in  [0:DRAM_WIDTH-1]  write data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  head consumed when out_valid & out_ready.
- out_ir  out  [0:12]  instruction word.
- out_irac  out  [0:3]  effective AC.
- out_dram_a, out_dram_b  out  [0:2]  DRAM A and B fields.
- out_dram_j  out  [1:10]  J field; bits 5:6 are always 0.
- out_par_err  out  1  DRAM word failed the odd-parity check.
- count  out  [$clog2(DEPTH+1)-1:0]  FIFO occupancy.

## Operation
- Address formation for in_word = w:
  - Default: addr = w[0:8].
  - If en_io_jrst and w[0:2]==7: addr = {3'b111, (w[3:6]==4'hF) ? 3'b111 : w[7:9], w[10:12]}.
- Stage L (lookup): on accept, w and addr are registered and the DRAM read is issued. Data returns on the next edge.
- Assembly:
  - A, B, J[1:4] come from the DRAM word.
  - J[7:10] = w[9:12] when en_io_jrst and w[0:8]==9'o254 (JRST); otherwise J[7:10] comes from the DRAM word.
  - IRAC = en_ac ? w[9:12] : 0.
  - out_par_err = ~^(all 15 DRAM bits), i.e. even parity flags an error.
  - en_io_jrst and en_ac are sampled at accept time and carried in stage L.
- The assembled entry is written to the FIFO tail; the head is presented on out_*.
- in_ready = ~reset & ~flush & (count + L_valid < DEPTH). It is computed from registered state only, so a pop does not free a slot in the same cycle.
- flush: count←0, L_valid←0, pointers←0. Flush wins over a simultaneous push or pop, and the pushed word is dropped. DRAM contents are unaffected.
- DRAM write/read collision on the same address in the same cycle: the read returns the old data (read-first).
- The DRAM has no reset; contents persist across reset.

## Timing
- Reset values: out_valid 0, count 0, in_ready 0 while reset is high, out_* data 0, internal pointers and L_valid 0. in_ready rises in the first cycle after reset is deasserted.
- Latency: a word accepted at edge N is in stage L after N. It is written to the FIFO at N+1, and out_valid is visible after N+1 if the FIFO was empty.
- Throughput: one accept and one pop per cycle. Simultaneous push-to-FIFO and pop leaves count unchanged.
- Full: when count + L_valid == DEPTH, in_ready is 0. An in-flight L entry always has a free slot.
- Empty: out_valid 0. Out data holds its last value; verification must not check it.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-operation clears everything asynchronously; no partial entry survives.

## Structure
- Package ir_dispatch_pkg:
  - dram_word_t packed struct (a, b, par, j_hi, j_lo).
  - dispatch_entry_t (ir, irac, a, b, j, par_err).
  - JRST_OPCODE = 9'o254.
  - Function dram_addr(w, en_io_jrst).
- Sub-module ir_dram_ram: synchronous single-read, single-write RAM, read-first.
  - Under KL10PV_TB it wraps sim_mem.
  - Otherwise it wraps dram_mem.
- The FIFO is inline: a dispatch_entry_t array with head/tail pointers.

## Test plan
- Write DRAM[0o200] = A=3, B=5, PAR=1, J[1:4]=0xA, J[7:10]=0x3; push 0o200_05 with en_ac=1 -> two cycles later out_dram_a=3, b=5, j=0x...A/3, irac=5, out_par_err=0.
- Push 0o254_07 (JRST, AC=7) with en_io_jrst=1 -> out_dram_j[7:10]=7, DRAM address 0o254. With en_io_jrst=0 -> j[7:10] from DRAM.
- I/O remap: push 0o7_17_1_3_ (w[3:6]=F) with en_io_jrst=1 -> DRAM read at {111,111,w[10:12]}. Check a DRAM word with even parity -> out_par_err=1.
- Fill: hold out_ready=0, push 6 words at DEPTH=4 -> exactly 4 accepted, count=4, in_ready=0. Then pop 1 -> one more accepted the following cycle, and order is preserved.
- Flush with FIFO at 3 entries, a lookup in flight and push asserted -> next cycle count=0, out_valid=0; the pushed word never appears.
- Reset pulse mid-stream, asynchronous and not clock-aligned -> out_valid=0 immediately. After release, DRAM contents are unchanged and the previous entries are re-readable by new pushes.

Source files
------------

// File: rtl/ir_dispatch_pkg.sv
// Shared types and address mapping for the EBOX IR dispatch queue.
// DRAM words and dispatch entries are big-endian (bit 0 is the MSB).
package ir_dispatch_pkg;

   localparam logic [0:8] JRST_OPCODE = 9'o254;

   typedef struct packed {
      logic [0:2] a;
      logic [0:2] b;
      logic       par;
      logic [0:3] j_hi;
      logic [0:3] j_lo;
   } dram_word_t;

   typedef struct packed {
      logic [0:12] ir;
      logic [0:3]  irac;
      logic [0:2]  a;
      logic [0:2]  b;
      logic [1:10] j;
      logic        par_err;
   } dispatch_entry_t;

   // I/O instructions (7XX) fold the device field into the top of the DRAM space.
   function automatic logic [0:8] dram_addr(input logic [0:12] w, input logic en_io_jrst);
      logic [0:8] addr;
      addr = w[0:8];
      if (en_io_jrst && (w[0:2] == 3'b111)) begin
         addr = {3'b111, (w[3:6] == 4'hF) ? 3'b111 : w[7:9], w[10:12]};
      end
      return addr;
   endfunction

endpackage

// File: rtl/dram_mem.sv
// Synthesis memory behind the dispatch RAM: one write port, one read port, read-first.
`ifndef KL10PV_TB
module dram_mem #(
   parameter int AW = 9,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Both ports update on the same edge, so a same-address read sees the old word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule
`endif

// File: rtl/ir_dram_ram.sv
// Dispatch RAM wrapper: synchronous single-read/single-write, read-first, no reset.
module ir_dram_ram #(
   parameter int AW = 9,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

`ifdef KL10PV_TB
   sim_mem #(.AW(AW), .DW(DW)) u_mem (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata)
   );
`else
   dram_mem #(.AW(AW), .DW(DW)) u_mem (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata)
   );
`endif

endmodule

// File: rtl/sim_mem.sv
// Simulation memory model used in the KL10PV bench build; read-first like dram_mem.
`ifdef KL10PV_TB
module sim_mem #(
   parameter int AW = 9,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

endmodule
`endif

// File: rtl/ir_dispatch_queue.sv
// Instruction dispatch queue: DRAM lookup stage L followed by a DEPTH-entry FIFO
// of decoded {IR, IRAC, A, B, J, parity} entries.
import ir_dispatch_pkg::*;

module ir_dispatch_queue #(
   parameter int DEPTH          = 4,
   parameter int DRAM_ADDR_BITS = 9,
   parameter int DRAM_WIDTH     = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [0:12]                    in_word,
   input  logic                           flush,
   input  logic                           en_io_jrst,
   input  logic                           en_ac,
   input  logic                           dram_we,
   input  logic [0:DRAM_ADDR_BITS-1]      dram_waddr,
   input  logic [0:DRAM_WIDTH-1]          dram_wdata,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [0:12]                    out_ir,
   output logic [0:3]                     out_irac,
   output logic [0:2]                     out_dram_a,
   output logic [0:2]                     out_dram_b,
   output logic [1:10]                    out_dram_j,
   output logic                           out_par_err,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Handshake: a transfer happens on the rising edge where valid & ready are both 1;
   // valid never waits for ready, and in_ready depends only on registered state,
   // reset and flush.
   logic                      accept;
   logic [0:DRAM_ADDR_BITS-1] rd_addr;
   logic [0:DRAM_WIDTH-1]     rdata;
   dram_word_t                dw;

   logic        l_valid;
   logic [0:12] l_word;
   logic        l_en_io_jrst;
   logic        l_en_ac;
   dispatch_entry_t l_entry;

   dispatch_entry_t fifo_q [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW:0]     occupancy;
   logic            push;
   logic            pop;
   dispatch_entry_t head_entry;

   assign occupancy = {1'b0, count} + {{CW{1'b0}}, l_valid};
   assign in_ready  = ~reset & ~flush & (occupancy < (CW+1)'(DEPTH));
   assign accept    = in_valid & in_ready;
   assign rd_addr   = DRAM_ADDR_BITS'(dram_addr(in_word, en_io_jrst));

   ir_dram_ram #(.AW(DRAM_ADDR_BITS), .DW(DRAM_WIDTH)) u_dram (
      .clk   (clk),
      .we    (dram_we),
      .waddr (dram_waddr),
      .wdata (dram_wdata),
      .re    (accept),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   assign dw = rdata;

   // Stage L: the word and its mode bits travel alongside the DRAM read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_valid      <= 1'b0;
         l_word       <= '0;
         l_en_io_jrst <= 1'b0;
         l_en_ac      <= 1'b0;
      end else begin
         l_valid <= accept;
         if (accept) begin
            l_word       <= in_word;
            l_en_io_jrst <= en_io_jrst;
            l_en_ac      <= en_ac;
         end
      end
   end

   always_comb begin
      l_entry         = '0;
      l_entry.ir      = l_word;
      l_entry.irac    = l_en_ac ? l_word[9:12] : 4'h0;
      l_entry.a       = dw.a;
      l_entry.b       = dw.b;
      l_entry.j       = {dw.j_hi, 2'b00,
                         (l_en_io_jrst && (l_word[0:8] == JRST_OPCODE)) ? l_word[9:12] : dw.j_lo};
      l_entry.par_err = ~^rdata;
   end

   // An in-flight L entry always has a reserved slot, so it is written unconditionally.
   assign push = l_valid;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            fifo_q[tail] <= l_entry;
            tail         <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   assign head_entry  = fifo_q[head];
   assign out_valid   = (count != '0);
   assign out_ir      = head_entry.ir;
   assign out_irac    = head_entry.irac;
   assign out_dram_a  = head_entry.a;
   assign out_dram_b  = head_entry.b;
   assign out_dram_j  = head_entry.j;
   assign out_par_err = head_entry.par_err;

endmodule

// File: tb/tb_ir_dispatch_queue.sv
// Bench for ir_dispatch_queue: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_ir_dispatch_queue;

   localparam int DEPTH = 4;
   localparam int AB    = 9;
   localparam int DW    = 15;
   localparam int EW    = 34;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [0:12]   in_word = '0;
   logic          flush = 1'b0;
   logic          en_io_jrst = 1'b0;
   logic          en_ac = 1'b0;
   logic          dram_we = 1'b0;
   logic [0:AB-1] dram_waddr = '0;
   logic [0:DW-1] dram_wdata = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [0:12]   out_ir;
   logic [0:3]    out_irac;
   logic [0:2]    out_dram_a;
   logic [0:2]    out_dram_b;
   logic [1:10]   out_dram_j;
   logic          out_par_err;
   logic [2:0]    count;

   ir_dispatch_queue #(.DEPTH(DEPTH), .DRAM_ADDR_BITS(AB), .DRAM_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .flush(flush), .en_io_jrst(en_io_jrst), .en_ac(en_ac),
      .dram_we(dram_we), .dram_waddr(dram_waddr), .dram_wdata(dram_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
      .out_irac(out_irac), .out_dram_a(out_dram_a), .out_dram_b(out_dram_b),
      .out_dram_j(out_dram_j), .out_par_err(out_par_err), .count(count)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] head_packed;
   assign head_packed = {out_ir, out_irac, out_dram_a, out_dram_b, out_dram_j, out_par_err};

   typedef struct {
      int waddr; int wdata; int word; bit io; bit ac;
      int ea; int eb; int ej; int eirac; int eerr;
   } vec_t;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            dram_m [512];
   logic [EW-1:0] exp_q [$];
   bit            pend_v = 1'b0;
   logic [EW-1:0] pend;
   vec_t          vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // Reference decode straight from the dispatch rules, using plain arithmetic.
   function automatic logic [EW-1:0] model_entry(input int w, input bit io, input bit ac);
      int addr, d, a, b, jhi, jlo, irac, err;
      addr = w / 16;
      if (io && (w / 1024) == 7)
         addr = 7 * 64 + ((((w / 64) % 16) == 15) ? 7 : (w / 8) % 8) * 8 + w % 8;
      d    = dram_m[addr];
      a    = d / 4096;
      b    = (d / 512) % 8;
      jhi  = (d / 16) % 16;
      jlo  = d % 16;
      if (io && (w / 16) == 'o254) jlo = w % 16;
      irac = ac ? w % 16 : 0;
      err  = ($countones(d) % 2 == 0) ? 1 : 0;
      return {13'(w), 4'(irac), 3'(a), 3'(b), 10'(jhi * 64 + jlo), 1'(err)};
   endfunction

   function automatic bit m_ready();
      return !reset && !flush && ((exp_q.size() + int'(pend_v)) < DEPTH);
   endfunction

   task automatic model_step();
      bit acc;
      acc = in_valid && m_ready();
      if (flush) begin
         exp_q.delete();
         pend_v = 1'b0;
      end else begin
         if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
         if (pend_v) exp_q.push_back(pend);
         pend_v = acc;
         if (acc) pend = model_entry(int'(in_word), en_io_jrst, en_ac);
      end
      if (dram_we) dram_m[dram_waddr] = int'(dram_wdata);
   endtask

   task automatic dram_write(input int addr, input int data);
      dram_we    = 1'b1;
      dram_waddr = AB'(addr);
      dram_wdata = DW'(data);
      @(negedge clk);
      dram_we       = 1'b0;
      dram_m[addr]  = data;
   endtask

   task automatic push(input int w, input bit io, input bit ac);
      in_valid   = 1'b1;
      in_word    = 13'(w);
      en_io_jrst = io;
      en_ac      = ac;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (in_ready) begin
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      timeout_fail("push");
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic int rand_word();
      case ($urandom_range(0, 3))
         0:       return 'o254 * 16 + int'($urandom_range(0, 15));
         1:       return 7 * 1024 + int'($urandom_range(0, 1023));
         default: return int'($urandom_range(0, 8191));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int fill_w [6];

      vecs[0] = '{'o200, 15267, 2053, 1'b1, 1'b1, 3, 5, 643, 5, 0};
      vecs[1] = '{'o254,  5468, 2759, 1'b1, 1'b1, 1, 2, 327, 7, 0};
      vecs[2] = '{'o254,  5468, 2759, 1'b0, 1'b0, 1, 2, 332, 0, 0};
      vecs[3] = '{'o773, 28673, 8147, 1'b1, 1'b1, 7, 0,   1, 3, 1};
      vecs[4] = '{'o775, 10550, 8147, 1'b0, 1'b1, 2, 4, 198, 3, 0};
      vecs[5] = '{'o762, 17298, 7538, 1'b1, 1'b0, 4, 1, 578, 0, 1};

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_ir", out_ir, 0);
      check("rst_out_j", out_dram_j, 0);
      reset = 1'b0;
      #1 check("in_ready_after_rst", in_ready, 1);
      @(negedge clk);

      for (int a = 0; a < 512; a++) dram_write(a, int'($urandom_range(0, 32767)));
      for (int i = 0; i < 6; i++) dram_write(vecs[i].waddr, vecs[i].wdata);

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].word, vecs[i].io, vecs[i].ac);
         check($sformatf("v%0d_lat_L", i), out_valid, 0);
         @(negedge clk);
         check($sformatf("v%0d_lat_out", i), out_valid, 1);
         check($sformatf("v%0d_ir", i), out_ir, vecs[i].word);
         check($sformatf("v%0d_a", i), out_dram_a, vecs[i].ea);
         check($sformatf("v%0d_b", i), out_dram_b, vecs[i].eb);
         check($sformatf("v%0d_j", i), out_dram_j, vecs[i].ej);
         check($sformatf("v%0d_irac", i), out_irac, vecs[i].eirac);
         check($sformatf("v%0d_par_err", i), out_par_err, vecs[i].eerr);
         pop_one();
         check($sformatf("v%0d_drained", i), count, 0);
      end

      // Fill past capacity with the head stalled
      for (int i = 0; i < 6; i++) fill_w[i] = 100 + i * 37;
      acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_word  = 13'(fill_w[acc]);
         #1;
         if (in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("fill_accepted", acc, 4);
      check("fill_count", count, 4);
      #1 check("fill_in_ready", in_ready, 0);
      check("fill_head", out_ir, fill_w[0]);
      in_valid  = 1'b1;
      in_word   = 13'(fill_w[4]);
      out_ready = 1'b1;
      #1 check("pop_no_same_cycle_ready", in_ready, 0);
      @(negedge clk);
      out_ready = 1'b0;
      #1 check("refill_ready", in_ready, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         check($sformatf("order%0d_valid", k), out_valid, 1);
         check($sformatf("order%0d_ir", k), out_ir, fill_w[k]);
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("order_drained", count, 0);

      // Flush with 3 queued, one in flight and a push offered
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_word  = 13'(200 + i);
         @(negedge clk);
      end
      check("pre_flush_count", count, 3);
      in_word = 13'(999);
      flush   = 1'b1;
      #1 check("flush_in_ready", in_ready, 0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_count", count, 0);
      check("flush_out_valid", out_valid, 0);
      @(negedge clk);
      check("flush_inflight_dropped", out_valid, 0);
      push(1234, 1'b0, 1'b0);
      @(negedge clk);
      check("post_flush_count", count, 1);
      check("post_flush_ir", out_ir, 1234);
      pop_one();

      // Asynchronous reset mid-stream
      push(vecs[1].word, 1'b1, 1'b1);
      push(vecs[3].word, 1'b1, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_count", count, 0);
      check("async_rst_in_ready", in_ready, 0);
      #4 reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_count", count, 0);
      push(vecs[0].word, vecs[0].io, vecs[0].ac);
      @(negedge clk);
      check("post_rst_dram_kept", head_packed, model_entry(vecs[0].word, 1'b1, 1'b1));
      check("post_rst_j", out_dram_j, vecs[0].ej);
      pop_one();

      // Randomized run against the reference model
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_q.delete();
      pend_v = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         check("rnd_count", count, exp_q.size());
         check("rnd_out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) check("rnd_head", head_packed, exp_q[0]);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_word    = 13'(rand_word());
         en_io_jrst = 1'($urandom_range(0, 1));
         en_ac      = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 40) == 0);
         dram_we    = ($urandom_range(0, 5) == 0);
         dram_waddr = $urandom_range(0, 1) ? in_word[0:8] : AB'($urandom_range(0, 511));
         dram_wdata = DW'($urandom_range(0, 32767));
         #1 check("rnd_in_ready", in_ready, m_ready());
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
      in_valid = 1'b0;
      dram_we  = 1'b0;
      flush    = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
